// File: rtl/as2650_bus_arbiter.sv
// Two-master arbiter and cycle sequencer for the AS2650 external bus.
// CPU has priority unless the host has been waiting STARVE_LIMIT cycles.
module as2650_bus_arbiter #(
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic              cpu_m_io,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              host_req,
    input  logic              host_rw,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rw,
    output logic              bus_m_io,
    output logic              bus_opreq,
    output logic              bus_wrp,
    output logic [DATA_W-1:0] bus_dout,
    output logic              bus_oe,
    input  logic [DATA_W-1:0] bus_din,
    output logic              host_owner
);

    localparam int unsigned WCNT_W   = 4;
    localparam int unsigned STARVE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_STROBE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                rw_q, rw_d;
    logic                m_io_q, m_io_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                host_q, host_d;
    logic                opreq_q, opreq_d;
    logic                wrp_q, wrp_d;
    logic                oe_q, oe_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                host_ack_q, host_ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                host_grant;
    logic                last_op;

    // Next-state, cycle latches and registered bus controls
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rw_d       = rw_q;
        m_io_d     = m_io_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        host_d     = host_q;
        rdata_d    = rdata_q;
        opreq_d    = 1'b0;
        wrp_d      = 1'b0;
        oe_d       = 1'b0;
        cpu_ack_d  = 1'b0;
        host_ack_d = 1'b0;
        host_grant = 1'b0;
        last_op    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req || host_req) begin
                    host_grant = host_req &&
                                 (!cpu_req || (starve_q >= STARVE_W'(STARVE_LIMIT)));
                    if (host_grant) begin
                        rw_d    = host_rw;
                        m_io_d  = 1'b1;
                        addr_d  = host_addr;
                        wdata_d = host_wdata;
                    end else begin
                        rw_d    = cpu_rw;
                        m_io_d  = cpu_m_io;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                    host_d  = host_grant;
                    opreq_d = 1'b1;
                    oe_d    = rw_d;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = S_STROBE;
                opreq_d = 1'b1;
                wrp_d   = rw_q;
                oe_d    = rw_q;
            end
            S_STROBE: begin
                if (WAIT_STATES == 0) begin
                    last_op = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    wcnt_d  = WCNT_W'(WAIT_STATES - 1);
                    opreq_d = 1'b1;
                    oe_d    = rw_q;
                end
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    last_op = 1'b1;
                end else begin
                    wcnt_d  = wcnt_q - WCNT_W'(1);
                    opreq_d = 1'b1;
                    oe_d    = rw_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Leaving the last opreq-high cycle: capture read data, pulse owner's ack in DONE
        if (last_op) begin
            state_d = S_DONE;
            if (!rw_q) begin
                rdata_d = bus_din;
            end
            cpu_ack_d  = !host_q;
            host_ack_d = host_q;
        end

        if (host_req && !host_grant) begin
            starve_d = (starve_q >= STARVE_W'(STARVE_LIMIT)) ? starve_q
                                                            : starve_q + STARVE_W'(1);
        end else begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            starve_q   <= '0;
            rw_q       <= 1'b0;
            m_io_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            host_q     <= 1'b0;
            opreq_q    <= 1'b0;
            wrp_q      <= 1'b0;
            oe_q       <= 1'b0;
            cpu_ack_q  <= 1'b0;
            host_ack_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            starve_q   <= starve_d;
            rw_q       <= rw_d;
            m_io_q     <= m_io_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            host_q     <= host_d;
            opreq_q    <= opreq_d;
            wrp_q      <= wrp_d;
            oe_q       <= oe_d;
            cpu_ack_q  <= cpu_ack_d;
            host_ack_q <= host_ack_d;
            rdata_q    <= rdata_d;
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign host_ack   = host_ack_q;
    assign rdata      = rdata_q;
    assign bus_addr   = addr_q;
    assign bus_rw     = rw_q;
    assign bus_m_io   = m_io_q;
    assign bus_opreq  = opreq_q;
    assign bus_wrp    = wrp_q;
    assign bus_dout   = wdata_q;
    assign bus_oe     = oe_q;
    assign host_owner = host_q;

endmodule
